// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, muldiv FSM encoding and a clog2 helper shared by the ALU and the muldiv unit.
package alu_pkg;
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [2:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX, MD_DONE} md_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
module div_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int CW = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [CW-1:0]    iter_count,
  output logic             last,
  output logic [WIDTH-1:0] quotient_mag,
  output logic [WIDTH-1:0] rem_mag
);
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] trial;
  logic fits;
  assign trial = {rem, quo[WIDTH-1]};
  assign fits = trial >= {1'b0, dvs};
  assign last = cnt == CW'(1);
  assign quotient_mag = quo;
  assign rem_mag = rem;
  // Dividend is pre-aligned to the top so short (word) runs still consume it MSB first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      quo <= dividend << (CW'(WIDTH) - iter_count);
      rem <= '0;
      dvs <= divisor;
      cnt <= iter_count;
    end else if (cnt != '0) begin
      rem <= fits ? trial[WIDTH-1:0] - dvs : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (registered multiplier, iterative divider).
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter bit WORD_OPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       operation,
  input  logic             op_word,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             error
);
  localparam int CW = clog2(WIDTH + 1);
  md_state_e state, state_nx;
  logic word, is_mul, is_div, is_rem, legal, sgn_a, sgn_b, accept, special, div_last;
  logic a_neg, b_neg, q_neg, r_neg, rem_q, word_q;
  logic [WIDTH-1:0] a_c, b_c, a_mag, b_mag, min_c, mul_res, spec_res, quo_mag, rem_mag, fix_res;
  logic [2*WIDTH-1:0] ma, mb, prod;

  function automatic logic [WIDTH-1:0] fit(input logic [WIDTH-1:0] x, input logic w);
    return w ? WIDTH'($signed(x[31:0])) : x;
  endfunction

  assign word   = WORD_OPS && op_word;
  assign is_mul = operation inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign is_div = operation inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign is_rem = operation inside {ALU_REM, ALU_REMU};
  assign legal  = (is_mul && !(word && operation != ALU_MUL)) || is_div;
  assign sgn_a  = operation inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign sgn_b  = operation inside {ALU_MULH, ALU_DIV, ALU_REM};
  assign a_c = !word ? operand_a : sgn_a ? WIDTH'($signed(operand_a[31:0])) : WIDTH'(operand_a[31:0]);
  assign b_c = !word ? operand_b : sgn_b ? WIDTH'($signed(operand_b[31:0])) : WIDTH'(operand_b[31:0]);
  // Full 2*WIDTH extension makes one unsigned multiply correct for every sign mix.
  assign ma = {{WIDTH{sgn_a & a_c[WIDTH-1]}}, a_c};
  assign mb = {{WIDTH{sgn_b & b_c[WIDTH-1]}}, b_c};
  assign prod = ma * mb;
  assign mul_res = operation == ALU_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  assign a_neg = sgn_a && a_c[WIDTH-1];
  assign b_neg = sgn_b && b_c[WIDTH-1];
  assign a_mag = a_neg ? -a_c : a_c;
  assign b_mag = b_neg ? -b_c : b_c;
  assign min_c = word ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};
  assign special = b_c == '0 || (sgn_b && a_c == min_c && &b_c);
  assign spec_res = b_c == '0 ? (is_rem ? a_c : '1) : (is_rem ? '0 : a_c);
  assign fix_res = rem_q ? (r_neg ? -rem_mag : rem_mag) : (q_neg ? -quo_mag : quo_mag);
  assign in_ready = state == MD_IDLE;
  assign out_valid = state == MD_MUL || state == MD_DONE;
  assign accept = in_valid && in_ready && !flush;

  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && legal && is_div && !special),
    .dividend(a_mag),
    .divisor(b_mag),
    .iter_count(word ? CW'(32) : CW'(WIDTH)),
    .last(div_last),
    .quotient_mag(quo_mag),
    .rem_mag(rem_mag)
  );

  // MUL presents the registered product immediately; DONE only holds it under backpressure.
  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (accept) state_nx = !legal ? MD_DONE : is_mul ? MD_MUL : special ? MD_DONE : MD_DIV;
      MD_MUL:  state_nx = out_ready ? MD_IDLE : MD_DONE;
      MD_DIV:  state_nx = div_last ? MD_FIX : MD_DIV;
      MD_FIX:  state_nx = MD_DONE;
      MD_DONE: state_nx = out_ready ? MD_IDLE : MD_DONE;
      default: state_nx = MD_IDLE;
    endcase
    if (flush) state_nx = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      result <= '0;
      error  <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      rem_q  <= 1'b0;
      word_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        error  <= !legal;
        result <= !legal ? '0 : fit(is_mul ? mul_res : spec_res, word);
        q_neg  <= a_neg ^ b_neg;
        r_neg  <= a_neg;
        rem_q  <= is_rem;
        word_q <= word;
      end else if (state == MD_FIX) begin
        result <= fit(fix_res, word_q);
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit (WIDTH=64, word ops on).
module tb_muldiv_unit;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0, in_valid = 0, op_word = 0, flush = 0, out_ready = 1;
  logic in_ready, out_valid, error;
  logic [4:0] operation = ALU_ADD;
  logic [63:0] operand_a = 0, operand_b = 0, result;
  int errors = 0, checks = 0, lat = 0;
  bit seen;

  muldiv_unit #(.WIDTH(64), .WORD_OPS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .op_word(op_word), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    operation = op; op_word = w; operand_a = a; operand_b = b; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp_r, input int exp_l, input logic exp_e);
    issue(op, w, a, b);
    chk({tag, " latency"}, 64'(lat), 64'(exp_l));
    chk({tag, " result"}, result, exp_r);
    chk({tag, " error"}, 64'(error), 64'(exp_e));
    tick();
    chk({tag, " drained"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset error", 64'(error), 64'd0);
    rst_n = 1;
    tick();

    run("MULH", ALU_MULH, 0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run("MULHU", ALU_MULHU, 0, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 1, 0);
    run("MUL", ALU_MUL, 0, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1, 0);
    run("MULHSU", ALU_MULHSU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run("DIV", ALU_DIV, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run("REM", ALU_REM, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run("DIVU", ALU_DIVU, 0, 64'd100, 64'd7, 64'd14, 66, 0);
    run("REMU", ALU_REMU, 0, 64'd100, 64'd7, 64'd2, 66, 0);
    run("DIVU by0", ALU_DIVU, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run("REMU by0", ALU_REMU, 0, 64'd5, 64'd0, 64'd5, 1, 0);
    run("DIV ovf", ALU_DIV, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    run("REM ovf", ALU_REM, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run("DIVW", ALU_DIV, 1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34, 0);
    run("REMUW", ALU_REMU, 1, 64'h0000_0001_0000_0007, 64'd3, 64'd1, 34, 0);
    run("MULW", ALU_MUL, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    run("MULHW illegal", ALU_MULH, 1, 64'd3, 64'd4, 64'd0, 1, 1);
    run("ADD illegal", ALU_ADD, 0, 64'd3, 64'd4, 64'd0, 1, 1);

    out_ready = 0;
    issue(ALU_MUL, 0, 64'd6, 64'd7);
    chk("bp latency", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp result", result, 64'd42);
    end
    out_ready = 1;
    tick();
    chk("bp drained", 64'(in_ready), 64'd1);

    operation = ALU_DIVU; op_word = 0; operand_a = 64'd100; operand_b = 64'd7; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (4) tick();
    flush = 1; in_valid = 1; operation = ALU_MUL; operand_a = 64'd3; operand_b = 64'd3;
    tick();
    flush = 0; in_valid = 0;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (70) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("flush no result", 64'(seen), 64'd0);
    run("DIV after flush", ALU_DIV, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);

    operation = ALU_DIVU; op_word = 0; operand_a = 64'd100; operand_b = 64'd7; in_valid = 1;
    tick();
    in_valid = 0;
    repeat (9) tick();
    rst_n = 0;
    tick();
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    chk("rst mid result", result, 64'd0);
    rst_n = 1;
    seen = 0;
    repeat (80) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("rst no result", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
